// File: rtl/pe_tile_sequencer.sv
// rtl/pe_tile_sequencer.sv - issues the CLR/PASS/MAC/RND/OUT instruction stream for one PE dot-product tile
// Issue strobes are decoded from the current state so operand reads line up with the PE instruction register.
`ifndef PE_OPCODE_BITWIDTH
`define PE_OPCODE_BITWIDTH 4
`endif
`ifndef PE_MODE_BITWIDTH
`define PE_MODE_BITWIDTH 2
`endif
`ifndef PE_VALUE_BITWIDTH
`define PE_VALUE_BITWIDTH 8
`endif
`ifndef PE_RND_OPCODE
`define PE_RND_OPCODE `PE_OPCODE_BITWIDTH'(5)
`endif
`ifndef PE_CLR_VALUE
`define PE_CLR_VALUE `PE_VALUE_BITWIDTH'(0)
`endif
`ifndef PE_PASS_VALUE
`define PE_PASS_VALUE `PE_VALUE_BITWIDTH'(1)
`endif
`ifndef PE_MAC_VALUE
`define PE_MAC_VALUE `PE_VALUE_BITWIDTH'(2)
`endif
`ifndef PE_OUT_VALUE
`define PE_OUT_VALUE `PE_VALUE_BITWIDTH'(3)
`endif

module pe_tile_sequencer #(
   parameter int LEN_WIDTH   = 12,
   parameter int MAC_DRAIN   = 1,
   parameter int OUT_LATENCY = 2,
   parameter logic [`PE_OPCODE_BITWIDTH-1:0] ALU_OPCODE = `PE_RND_OPCODE ^ `PE_OPCODE_BITWIDTH'(1)
) (
   input  logic                                                                clk,
   input  logic                                                                rst_n,
   input  logic                                                                cmd_valid,
   output logic                                                                cmd_ready,
   input  logic [`PE_MODE_BITWIDTH-1:0]                                        cmd_mode,
   input  logic [LEN_WIDTH-1:0]                                                cmd_len,
   input  logic [`PE_VALUE_BITWIDTH-1:0]                                       cmd_shift,
   input  logic                                                                cmd_bias,
   input  logic                                                                opnd_avail,
   output logic                                                                opnd_rd_en,
   output logic                                                                opnd_rd_bias,
   output logic [LEN_WIDTH-1:0]                                                opnd_rd_idx,
   output logic [`PE_OPCODE_BITWIDTH+`PE_MODE_BITWIDTH+`PE_VALUE_BITWIDTH-1:0] pe_inst,
   output logic                                                                pe_inst_valid,
   output logic                                                                res_valid,
   input  logic                                                                res_ready,
   output logic                                                                busy
);

   localparam int OPW    = `PE_OPCODE_BITWIDTH;
   localparam int MW     = `PE_MODE_BITWIDTH;
   localparam int VW     = `PE_VALUE_BITWIDTH;
   localparam int INST_W = OPW + MW + VW;

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_CLR   = 4'd1;
   localparam logic [3:0] S_BIAS  = 4'd2;
   localparam logic [3:0] S_MAC   = 4'd3;
   localparam logic [3:0] S_DRAIN = 4'd4;
   localparam logic [3:0] S_RND   = 4'd5;
   localparam logic [3:0] S_OUT   = 4'd6;
   localparam logic [3:0] S_WAIT  = 4'd7;
   localparam logic [3:0] S_DONE  = 4'd8;

   // One shared delay counter serves both DRAIN and WAIT; they never overlap.
   localparam int DLY_MAX = (MAC_DRAIN > OUT_LATENCY) ? MAC_DRAIN : OUT_LATENCY;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);
   localparam logic [DLY_W-1:0] DRAIN_LAST = DLY_W'(MAC_DRAIN - 1);
   localparam logic [DLY_W-1:0] WAIT_LAST  = DLY_W'((OUT_LATENCY > 1) ? OUT_LATENCY - 2 : 0);

   logic [3:0]           state_q, state_d;
   logic [MW-1:0]        mode_q, mode_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [VW-1:0]        shift_q, shift_d;
   logic                 bias_q, bias_d;
   logic [DLY_W-1:0]     dly_q, dly_d;
   logic [INST_W-1:0]    last_inst_q, last_inst_d;

   logic                 accept;
   logic                 issue;
   logic [OPW-1:0]       inst_op;
   logic [VW-1:0]        inst_val;
   logic                 rd_en;
   logic                 rd_bias;
   logic [INST_W-1:0]    inst_cur;

   assign cmd_ready = rst_n && (state_q == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      bias_d   = bias_q;
      dly_d    = dly_q;
      issue    = 1'b0;
      inst_op  = ALU_OPCODE;
      inst_val = `PE_CLR_VALUE;
      rd_en    = 1'b0;
      rd_bias  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               mode_d  = cmd_mode;
               len_d   = cmd_len;
               shift_d = cmd_shift;
               bias_d  = cmd_bias;
               cnt_d   = '0;
               dly_d   = '0;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            issue    = 1'b1;
            inst_val = `PE_CLR_VALUE;
            if (bias_q)
               state_d = S_BIAS;
            else if (len_q != '0)
               state_d = S_MAC;
            else
               state_d = S_RND;
         end
         S_BIAS: begin
            if (opnd_avail) begin
               issue    = 1'b1;
               inst_val = `PE_PASS_VALUE;
               rd_en    = 1'b1;
               rd_bias  = 1'b1;
               state_d  = (len_q != '0) ? S_MAC : S_RND;
            end
         end
         S_MAC: begin
            if (opnd_avail) begin
               issue    = 1'b1;
               inst_val = `PE_MAC_VALUE;
               rd_en    = 1'b1;
               if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                  dly_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + LEN_WIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            if (dly_q == DRAIN_LAST) begin
               dly_d   = '0;
               state_d = S_RND;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         S_RND: begin
            issue    = 1'b1;
            inst_op  = `PE_RND_OPCODE;
            inst_val = shift_q;
            state_d  = S_OUT;
         end
         S_OUT: begin
            issue    = 1'b1;
            inst_val = `PE_OUT_VALUE;
            dly_d    = '0;
            state_d  = (OUT_LATENCY > 1) ? S_WAIT : S_DONE;
         end
         S_WAIT: begin
            if (dly_q == WAIT_LAST) begin
               dly_d   = '0;
               state_d = S_DONE;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         S_DONE: begin
            // No accept here: a new CLR would wipe the result before it is consumed.
            if (res_ready)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      inst_cur    = {inst_op, mode_q, inst_val};
      last_inst_d = issue ? inst_cur : last_inst_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mode_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         shift_q     <= '0;
         bias_q      <= 1'b0;
         dly_q       <= '0;
         last_inst_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         bias_q      <= bias_d;
         dly_q       <= dly_d;
         last_inst_q <= last_inst_d;
      end
   end

   assign pe_inst       = last_inst_d;
   assign pe_inst_valid = issue;
   assign opnd_rd_en    = rd_en;
   assign opnd_rd_bias  = rd_bias;
   assign opnd_rd_idx   = cnt_q;
   assign res_valid     = (state_q == S_DONE);
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// tb/tb_pe_tile_sequencer.sv - randomized scoreboard bench for pe_tile_sequencer
module tb_pe_tile_sequencer;

   localparam int LW          = 12;
   localparam int MAC_DRAIN   = 1;
   localparam int OUT_LATENCY = 2;
   localparam logic [3:0] OP_RND = 4'd5;
   localparam logic [3:0] OP_ALU = 4'd4;
   localparam logic [7:0] V_CLR  = 8'd0;
   localparam logic [7:0] V_PASS = 8'd1;
   localparam logic [7:0] V_MAC  = 8'd2;
   localparam logic [7:0] V_OUT  = 8'd3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_mode = '0;
   logic [LW-1:0] cmd_len = '0;
   logic [7:0]    cmd_shift = '0;
   logic          cmd_bias = 1'b0;
   logic          opnd_avail = 1'b0;
   logic          opnd_rd_en;
   logic          opnd_rd_bias;
   logic [LW-1:0] opnd_rd_idx;
   logic [13:0]   pe_inst;
   logic          pe_inst_valid;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          busy;

   pe_tile_sequencer #(
      .LEN_WIDTH   (LW),
      .MAC_DRAIN   (MAC_DRAIN),
      .OUT_LATENCY (OUT_LATENCY)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_mode      (cmd_mode),
      .cmd_len       (cmd_len),
      .cmd_shift     (cmd_shift),
      .cmd_bias      (cmd_bias),
      .opnd_avail    (opnd_avail),
      .opnd_rd_en    (opnd_rd_en),
      .opnd_rd_bias  (opnd_rd_bias),
      .opnd_rd_idx   (opnd_rd_idx),
      .pe_inst       (pe_inst),
      .pe_inst_valid (pe_inst_valid),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int n_prt = 0;
   bit chk_en = 1'b0;
   bit chk_rdy = 1'b1;
   logic exp_rdy = 1'b1;
   logic exp_busy = 1'b0;
   logic exp_res = 1'b0;

   typedef struct {
      int         cyc;
      logic [13:0] inst;
      bit         rd;
      bit         bias;
      int         idx;
   } exp_t;
   exp_t exp_q[$];

   bit     av[$];
   int     cur_pct;
   logic [63:0] cur_mask;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         if (n_prt < 60)
            $display("FAIL %s: cycle %0d actual 0x%0h required 0x%0h", name, cyc, act, req);
         n_prt++;
      end
   endtask

   function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] m, input logic [7:0] v);
      return {op, m, v};
   endfunction

   task automatic push(input int c, input logic [13:0] inst, input bit rd, input bit b, input int idx);
      exp_t e;
      e.cyc = c; e.inst = inst; e.rd = rd; e.bias = b; e.idx = idx;
      exp_q.push_back(e);
   endtask

   task automatic get_av(input int o, output bit b);
      while (av.size() <= o) begin
         if (av.size() < 64 && cur_mask[av.size()])
            av.push_back(1'b0);
         else
            av.push_back($urandom_range(99) >= cur_pct);
      end
      b = av[o];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every instruction issue against the scoreboard, and level outputs every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         if (chk_rdy) check("cmd_ready", cmd_ready, exp_rdy);
         check("busy", busy, exp_busy);
         check("res_valid", res_valid, exp_res);
         while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            check("missed_inst_cycle", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (pe_inst_valid || opnd_rd_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_inst", {pe_inst_valid, opnd_rd_en, pe_inst}, 0);
            end else begin
               e = exp_q.pop_front();
               check("inst_cycle", cyc, e.cyc);
               check("pe_inst_valid", pe_inst_valid, 1);
               check("pe_inst", pe_inst, e.inst);
               check("opnd_rd_en", opnd_rd_en, e.rd);
               check("opnd_rd_bias", opnd_rd_bias, e.bias);
               if (e.rd && !e.bias) check("opnd_rd_idx", opnd_rd_idx, e.idx);
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cmd_valid  = 1'b0;
         opnd_avail = 1'($urandom_range(1));
         res_ready  = 1'($urandom_range(1));
         exp_rdy = 1'b1; exp_busy = 1'b0; exp_res = 1'b0;
         tick();
      end
   endtask

   // Reference schedule: CLR next cycle, each operand read takes the first available cycle,
   // drain only when MACs exist, then RND, OUT, result OUT_LATENCY after OUT.
   task automatic run_tile(input logic [1:0] mode, input int len, input logic [7:0] shift, input bit bias,
                           input int pct, input logic [63:0] mask, input int hold, input bit early);
      int a, t, res, h;
      bit b;
      a = cyc;
      cur_pct = pct;
      cur_mask = mask;
      av.delete();
      push(a + 1, mk(OP_ALU, mode, V_CLR), 0, 0, 0);
      t = a + 2;
      for (int r = 0; r < len + int'(bias); r++) begin
         get_av(t - a, b);
         while (!b) begin
            t++;
            get_av(t - a, b);
         end
         if (bias && r == 0)
            push(t, mk(OP_ALU, mode, V_PASS), 1, 1, 0);
         else
            push(t, mk(OP_ALU, mode, V_MAC), 1, 0, r - int'(bias));
         t++;
      end
      if (len > 0) t += MAC_DRAIN;
      push(t, mk(OP_RND, mode, shift), 0, 0, 0);
      push(t + 1, mk(OP_ALU, mode, V_OUT), 0, 0, 0);
      res = t + 1 + OUT_LATENCY;
      h = res + hold;
      for (int c = a; c <= h; c++) begin
         get_av(c - a, b);
         opnd_avail = b;
         exp_rdy  = (c == a);
         exp_busy = (c != a);
         exp_res  = (c >= res);
         res_ready = (c == h) ? 1'b1 : ((c >= res) ? 1'b0 : 1'($urandom_range(1)));
         if (c == a) begin
            cmd_valid = 1'b1;
            cmd_mode  = mode;
            cmd_len   = LW'(len);
            cmd_shift = shift;
            cmd_bias  = bias;
         end else begin
            cmd_valid = (early && c >= res) ? 1'b1 : 1'($urandom_range(1));
            cmd_mode  = 2'($urandom);
            cmd_len   = LW'($urandom);
            cmd_shift = 8'($urandom);
            cmd_bias  = 1'($urandom);
         end
         tick();
      end
   endtask

   task automatic reset_mid_tile();
      int a;
      a = cyc;
      push(a + 1, mk(OP_ALU, 2'd1, V_CLR), 0, 0, 0);
      push(a + 2, mk(OP_ALU, 2'd1, V_MAC), 1, 0, 0);
      push(a + 3, mk(OP_ALU, 2'd1, V_MAC), 1, 0, 1);
      for (int c = a; c <= a + 3; c++) begin
         opnd_avail = 1'b1;
         res_ready  = 1'b0;
         cmd_valid  = (c == a);
         cmd_mode   = 2'd1;
         cmd_len    = LW'(8);
         cmd_shift  = 8'd2;
         cmd_bias   = 1'b0;
         exp_rdy  = (c == a);
         exp_busy = (c != a);
         exp_res  = 1'b0;
         tick();
      end
      rst_n = 1'b0;
      chk_rdy = 1'b0;
      exp_busy = 1'b0;
      exp_res = 1'b0;
      cmd_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_rdy = 1'b1;
      idle(2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: cycle %0d actual running required finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len, sel;
      @(negedge clk);
      check("rst_pe_inst", pe_inst, 0);
      check("rst_pe_inst_valid", pe_inst_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_opnd_rd_en", opnd_rd_en, 0);
      check("rst_opnd_rd_idx", opnd_rd_idx, 0);
      tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      idle(2);

      run_tile(2'd2, 4, 8'd3, 1'b0, 0, 64'h0, 0, 1'b0);
      run_tile(2'd2, 4, 8'd3, 1'b0, 0, 64'h18, 0, 1'b0);
      run_tile(2'd0, 0, 8'd5, 1'b1, 0, 64'h0, 0, 1'b0);
      run_tile(2'd1, 3, 8'd1, 1'b0, 0, 64'h0, 5, 1'b1);
      run_tile(2'd1, 2, 8'd0, 1'b1, 30, 64'h0, 1, 1'b0);
      run_tile(2'd3, 0, 8'd0, 1'b0, 0, 64'h0, 0, 1'b0);
      reset_mid_tile();
      run_tile(2'd3, 8, 8'd7, 1'b0, 0, 64'h0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(9);
         if (sel == 0)      len = 0;
         else if (sel == 1) len = $urandom_range(200);
         else               len = $urandom_range(12, 1);
         run_tile(2'($urandom), len, 8'($urandom), 1'($urandom), $urandom_range(60),
                  64'h0, $urandom_range(4), 1'($urandom));
         if ($urandom_range(3) == 0) idle($urandom_range(2));
      end

      run_tile(2'd2, (1 << LW) - 1, 8'd9, 1'b1, 0, 64'h0, 0, 1'b0);
      idle(3);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
